// File: rtl/led_shift_pkg.sv
// Shared types for the LED pattern generator: pattern modes, shift direction
// and the per-mode seed function.
package led_shift_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE   = 2'd0,
        MODE_FILL     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_JOHNSON  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Widest LED bank the seed function can describe; callers cast down to WIDTH.
    localparam int unsigned SEED_MAX = 256;

    function automatic logic [SEED_MAX-1:0] seed(input mode_e mode, input dir_e dir,
                                                 input int unsigned width);
        logic [SEED_MAX-1:0] one;
        one  = {{(SEED_MAX-1){1'b0}}, 1'b1};
        seed = '0;
        if (mode == MODE_ROTATE || mode == MODE_PINGPONG) begin
            seed = (dir == DIR_RIGHT) ? (one << (width - 1)) : one;
        end
    endfunction

endpackage

// File: rtl/led_shift_gen_prescaler.sv
// Step prescaler: counts 0..CLK_DIV-1 while enabled and strobes tick on the
// last count; clr restarts the count from zero.
module led_prescaler #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_shift_gen.sv
// Parametrised LED pattern generator (rotate / fill / ping-pong / Johnson).
// Optional PWM dimming with a `duty` input when LEDSHIFT_PWM_EN is defined.
module led_shift_gen
    import led_shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
`ifdef LEDSHIFT_PWM_EN
    input  logic [2:0]       duty,
`endif
    output logic [WIDTH-1:0] led,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RESET_PAT = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pat_q, pat_d;
    mode_e            mode_q, mode_in;
    dir_e             pdir_q, pdir_d, dir_in;
    logic             reload;

    assign mode_in = mode_e'(mode);
    assign dir_in  = dir_e'(dir);
    // A mode switch reseeds exactly like an explicit load.
    assign reload  = load || (mode_in != mode_q);

    led_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (reload),
        .tick  (tick)
    );

    always_comb begin
        pat_d  = pat_q;
        pdir_d = pdir_q;
        if (reload) begin
            pat_d  = WIDTH'(seed(mode_in, dir_in, WIDTH));
            pdir_d = dir_in;
        end else if (tick) begin
            case (mode_q)
                MODE_ROTATE: begin
                    pat_d = (dir_in == DIR_RIGHT) ? {pat_q[0], pat_q[WIDTH-1:1]}
                                                  : {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                end
                MODE_FILL: begin
                    if (&pat_q) begin
                        pat_d = '0;
                    end else begin
                        pat_d = (dir_in == DIR_RIGHT) ? {1'b1, pat_q[WIDTH-1:1]}
                                                      : {pat_q[WIDTH-2:0], 1'b1};
                    end
                end
                MODE_PINGPONG: begin
                    // Flip as the bit lands on an end so the next step heads back.
                    if (pdir_q == DIR_LEFT) begin
                        pat_d = {pat_q[WIDTH-2:0], 1'b0};
                        if (pat_q[WIDTH-2]) pdir_d = DIR_RIGHT;
                    end else begin
                        pat_d = {1'b0, pat_q[WIDTH-1:1]};
                        if (pat_q[1]) pdir_d = DIR_LEFT;
                    end
                end
                MODE_JOHNSON: begin
                    pat_d = (dir_in == DIR_RIGHT) ? {~pat_q[0], pat_q[WIDTH-1:1]}
                                                  : {pat_q[WIDTH-2:0], ~pat_q[WIDTH-1]};
                end
                default: pat_d = pat_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= RESET_PAT;
            mode_q <= MODE_ROTATE;
            pdir_q <= DIR_LEFT;
        end else begin
            pat_q  <= pat_d;
            mode_q <= mode_in;
            pdir_q <= pdir_d;
        end
    end

`ifdef LEDSHIFT_PWM_EN
    logic [2:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_q + 3'd1;
        end
    end

    assign led = pat_q & {WIDTH{pc_q < duty}};
`else
    assign led = pat_q;
`endif

endmodule
